// File: rtl/mem_access_seq_pkg.sv
// rtl/mem_access_seq_pkg.sv - shared types and size codes for the data-memory access sequencer
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_CAPTURE,
    ST_MERGE_WR,
    ST_WR,
    ST_DONE
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  // Reserved size code 11 behaves as a word access everywhere.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] s;
    s = norm_size(size);
    return ((s == SZ_WORD) && (addr_lo != 2'b00)) || ((s == SZ_HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - request handshake and data-memory bus of the access sequencer
interface mem_access_seq_if;
  logic        start;
  logic        op_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  start, op_store, size, addr, wdata, mem_rdata,
    output busy, done, misalign, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    output start, op_store, size, addr, wdata, mem_rdata,
    input  busy, done, misalign, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_access_seq_store_merge.sv
// rtl/mem_access_seq_store_merge.sv - merges store data into the low half/byte of a read word
module store_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] mdr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = wdata;
    case (size)
      SZ_HALF: merged = {mdr[31:16], wdata[15:0]};
      SZ_BYTE: merged = {mdr[31:8],  wdata[7:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle load/store sequencer with MDR; alignment fault via MEM_ALIGN_CHECK_EN
module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_access_seq_if.master        bus,
  output logic [31:0]             mdr_out,
  output logic [1:0]              load_size_control
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_store_q;
  logic [31:0]      wdata_q;
  logic [31:0]      merged;
  logic             fault;
  logic [1:0]       req_size;

  assign req_size = norm_size(bus.size);

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = is_misaligned(bus.size, bus.addr[1:0]);
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus.addr[1:0];
  assign fault          = 1'b0;
`endif

  // Merge from the incoming read word so the write data is ready as MERGE_WR begins.
  store_merge u_merge (
    .mdr    (bus.mem_rdata),
    .wdata  (wdata_q),
    .size   (load_size_control),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      op_store_q        <= 1'b0;
      wdata_q           <= '0;
      mdr_out           <= '0;
      load_size_control <= SZ_WORD;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.misalign      <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wr        <= 1'b0;
      bus.mem_wdata     <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_store_q        <= bus.op_store;
            wdata_q           <= bus.wdata;
            load_size_control <= req_size;
            bus.mem_addr      <= {bus.addr[31:2], 2'b00};
            bus.busy          <= 1'b1;
            if (fault) begin
              state        <= ST_DONE;
              bus.done     <= 1'b1;
              bus.misalign <= 1'b1;
            end else if (bus.op_store && (req_size == SZ_WORD)) begin
              state         <= ST_WR;
              bus.mem_wr    <= 1'b1;
              bus.mem_wdata <= bus.wdata;
            end else begin
              state <= ST_RD_WAIT;
              cnt   <= CNT_W'(MEM_LAT - 1);
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_CAPTURE: begin
          mdr_out <= bus.mem_rdata;
          if (op_store_q) begin
            state         <= ST_MERGE_WR;
            bus.mem_wr    <= 1'b1;
            bus.mem_wdata <= merged;
          end else begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
          end
        end
        ST_MERGE_WR, ST_WR: begin
          state    <= ST_DONE;
          bus.done <= 1'b1;
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          bus.busy     <= 1'b0;
          bus.mem_addr <= '0;
        end
        default: begin
          state        <= ST_IDLE;
          bus.busy     <= 1'b0;
          bus.mem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - randomized self-checking bench for mem_access_seq against a transaction-level model
module tb_mem_access_seq;

  localparam int LAT = 3;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mdr_out;
  logic [1:0]  lsc;

  always #5 clk = ~clk;

  mem_access_seq_if bus();

  mem_access_seq #(.MEM_LAT(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .mdr_out           (mdr_out),
    .load_size_control (lsc)
  );

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] apipe   [LAT];
  logic        load_mem;
  logic [31:0] exp_mdr;
  int          checks = 0;
  int          failures = 0;

  // Memory with LAT-cycle read latency: rdata reflects the address seen LAT edges earlier.
  assign bus.mem_rdata = mem[apipe[LAT-1][7:2]];

  always @(posedge clk) begin
    apipe[0] <= bus.mem_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit st, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    logic [1:0]  nsz;
    logic [31:0] word_old, keep, exp_wdata, wr_data, sel, sel_mask;
    bit          fault, mis_seen;
    int          exp_done, exp_wr_k, wr_cnt, wr_k, done_k;
    nsz      = (sz == 2'b11) ? 2'b00 : sz;
    fault    = ALIGN && (((nsz == 2'b00) && (a[1:0] != 2'b00)) || ((nsz == 2'b01) && a[0]));
    word_old = ref_mem[a[7:2]];
    exp_wr_k = 0;
    exp_wdata = '0;
    if (fault) begin
      exp_done = 1;
    end else if (!st) begin
      exp_done = LAT + 2;
      exp_mdr  = word_old;
    end else if (nsz == 2'b00) begin
      exp_done  = 2;
      exp_wr_k  = 1;
      exp_wdata = wd;
    end else begin
      exp_done  = LAT + 3;
      exp_wr_k  = LAT + 2;
      exp_mdr   = word_old;
      keep      = (nsz == 2'b01) ? 32'hFFFF_0000 : 32'hFFFF_FF00;
      exp_wdata = (word_old & keep) | (wd & ~keep);
    end
    if (exp_wr_k != 0) ref_mem[a[7:2]] = exp_wdata;

    @(negedge clk);
    bus.start = 1'b1; bus.op_store = st; bus.size = sz; bus.addr = a; bus.wdata = wd;
    wr_cnt = 0; wr_k = 0; done_k = 0; mis_seen = 1'b0; wr_data = '0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (k == 1) begin
        check("busy_k1", 32'(bus.busy), 32'd1);
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
      end
      if (bus.mem_wr) begin wr_cnt++; wr_k = k; wr_data = bus.mem_wdata; end
      if (bus.done) begin done_k = k; mis_seen = bus.misalign; end
    end
    check("done_cycle", 32'(done_k), 32'(exp_done));
    check("wr_count", 32'(wr_cnt), (exp_wr_k != 0) ? 32'd1 : 32'd0);
    if (exp_wr_k != 0) begin
      check("wr_cycle", 32'(wr_k), 32'(exp_wr_k));
      check("wr_data", wr_data, exp_wdata);
    end
    check("misalign", 32'(mis_seen), 32'(fault));
    check("mdr", mdr_out, exp_mdr);
    check("lsc", 32'(lsc), 32'(nsz));
    if (!st && !fault) begin
      sel_mask = (nsz == 2'b01) ? 32'h0000_FFFF : (nsz == 2'b10) ? 32'h0000_00FF : 32'hFFFF_FFFF;
      sel = (lsc == 2'b01) ? {16'h0, mdr_out[15:0]} : (lsc == 2'b10) ? {24'h0, mdr_out[7:0]} : mdr_out;
      check("selector", sel, word_old & sel_mask);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_addr", bus.mem_addr, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.op_store = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
    load_mem = 1'b1;
    exp_mdr  = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[32'h40 >> 2] = 32'hAABB_CCDD;
    ref_mem[32'h80 >> 2] = 32'h1122_3344;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_mdr", mdr_out, 32'd0);
    check("rst_lsc", 32'(lsc), 32'd0);
    check("rst_mis", 32'(bus.misalign), 32'd0);
    reset = 1'b0;
    load_mem = 1'b0;

    run_op(1'b0, 2'b00, 32'h40, 32'h0, 1'b0);
    run_op(1'b0, 2'b10, 32'h40, 32'h0, 1'b0);
    run_op(1'b1, 2'b10, 32'h80, 32'hFFFF_FF99, 1'b0);
    run_op(1'b1, 2'b01, 32'h80, 32'h0000_BEEF, 1'b0);
    run_op(1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, 1'b1);
    run_op(1'b0, 2'b01, 32'h20, 32'h0, 1'b0);

    // Abort a load by reset two cycles after accept.
    @(negedge clk);
    bus.start = 1'b1; bus.op_store = 1'b0; bus.size = 2'b01; bus.addr = 32'h20;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_mdr = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstab_busy", 32'(bus.busy), 32'd0);
      check("rstab_done", 32'(bus.done), 32'd0);
      check("rstab_wr", 32'(bus.mem_wr), 32'd0);
      check("rstab_mdr", mdr_out, 32'd0);
      check("rstab_lsc", 32'(lsc), 32'd0);
    end
    reset = 1'b0;

    run_op(1'b0, 2'b00, 32'h42, 32'h0, 1'b0);
    run_op(1'b0, 2'b01, 32'h42, 32'h0, 1'b0);
    run_op(1'b1, 2'b11, 32'h41, 32'h1234_5678, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multicycle sequencer for all data-memory accesses of the CPU datapath.
- Executes lw/lh/lb and sw/sh/sb:
  - drives memory address and write strobe;
  - owns the MDR register;
  - drives load_size_control to the load-size selector (00 word, 01 half, 10 byte; selector takes mdr[15:0]/mdr[7:0] zero-extended).
- sh/sb have no byte lanes, so they are done as read-modify-write of the low half/byte of the addressed word.
- Sits between the main control FSM (start/done handshake) and the data memory.

Parameters:
- MEM_LAT, 1, read latency in cycles from mem_addr valid to mem_rdata valid (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe from main control; sampled only in IDLE.
- op_store  in  1  1 = store, 0 = load; sampled with start.
- size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word); sampled with start.
- addr  in  32  byte address; sampled with start.
- wdata  in  32  store data; sampled with start.
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  memory address.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mdr_out  out  32  MDR contents, feeds the load-size selector.
- load_size_control  out  2  size code for the selector; equals latched size, 11 forced to 00.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  alignment fault pulse; constant 0 without the optional feature.

Behaviour:
- Reset (sync): state IDLE, all outputs and internal registers 0 (mdr_out 0, load_size_control 00). Reset mid-operation aborts the access; mem_wr is 0 from the cycle after the reset edge; no done.
- IDLE: start=1 at edge t latches op_store/size/addr/wdata. start while busy is ignored (not queued).
- mem_addr = {addr_q[31:2], 2'b00} in every non-IDLE state; 0 in IDLE.
- States: IDLE, RD_WAIT, CAPTURE, MERGE_WR, WR, DONE.
- Load: IDLE -> RD_WAIT (MEM_LAT cycles, down-counter) -> CAPTURE (mdr <= mem_rdata) -> DONE -> IDLE. done at cycle t+MEM_LAT+2; mdr_out valid from DONE onward.
- sw: IDLE -> WR (mem_wr=1, mem_wdata=wdata_q) -> DONE; done at t+2. mdr not updated.
- sh/sb: IDLE -> RD_WAIT -> CAPTURE -> MERGE_WR -> DONE; done at t+MEM_LAT+3.
  - MERGE_WR: mem_wr=1, mem_wdata = {mdr[31:16], wdata_q[15:0]} (sh) or {mdr[31:8], wdata_q[7:0]} (sb).
- mem_wr is high only in WR or MERGE_WR, exactly one cycle per store.
- mdr_out holds its value between accesses; only CAPTURE writes it.
- load_size_control holds the latched size until the next accepted start.
- DONE always returns to IDLE. A start in the DONE cycle is ignored; back-to-back accepted starts are at least one IDLE cycle apart.
- RD_WAIT counter loads MEM_LAT-1 on entry and exits when it reaches 0.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: at accept, a misaligned request faults:
  - word (or 11) with addr[1:0]!=0;
  - half with addr[0]=1.
  - The FSM goes IDLE -> DONE directly, with misalign=1 and done=1 in that DONE cycle.
  - No memory read or write is issued; mdr unchanged.
- Not defined: addr[1:0] is ignored (word-aligned access) and misalign is tied 0.

Decomposition:
- Shared package mem_access_pkg:
  - state enum;
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - MEM_LAT_MAX=7.
- Sub-module store_merge: combinational merge of mdr and wdata by size. Only sub-module; the FSM stays in the top.

Test Plan:
- MEM_LAT=1, mem[0x40]=0xAABBCCDD, lw addr 0x40 -> mem_addr 0x40, mdr_out 0xAABBCCDD, load_size_control 00, done at t+3, mem_wr never high.
- Same memory, lb addr 0x40 -> load_size_control 10, mdr_out 0xAABBCCDD, done at t+3; selector output 0x000000DD.
- mem[0x80]=0x11223344, sb addr 0x80 wdata 0xFFFFFF99 -> one mem_wr pulse at t+3 with data 0x11223399, done at t+4. Then sh wdata 0x0000BEEF -> written 0x1122BEEF.
- sw addr 0x10 wdata 0xDEADBEEF -> mem_wr pulse at t+1 with 0xDEADBEEF, done at t+2. start held high through the access -> no second request accepted before IDLE.
- MEM_LAT=3, lh addr 0x20 -> done at t+5; reset asserted at t+2 of a repeat lh -> IDLE next cycle, no done, no mem_wr, mdr_out 0.
- MEM_ALIGN_CHECK_EN defined, lw addr 0x42 -> misalign=done=1 at t+1, no memory traffic. lh addr 0x42 -> normal access, no fault.
